// File: rtl/gpio_bank.sv
// gpio_bank -- register-mapped bank of general purpose I/O pins.
//
// Each pad has an output value, an output enable, a pull-up and a pull-down
// control, all driven from registers. Pad inputs are synchronized, optionally
// debounced, and edge-detected into a sticky interrupt status register.
//
// Optional feature: define GPIO_BANK_DEBOUNCE_EN to compile in a per-pin
// debounce filter (p_debounce_pw2-bit counter per pin). Without it the
// filtered input is simply the synchronizer output.
//
// Register map (word address on i_addr):
//   0 OUT, 1 OUT_EN, 2 PULLUP, 3 PULLDOWN, 4 IN (read-only),
//   5 IRQ_EN, 6 IRQ_MODE (0 rising, 1 falling), 7 IRQ_STATUS (write-1-to-clear)
//
// Ports:
//   i_clk           clock, all state on rising edge
//   i_rst           asynchronous active-high reset
//   i_addr          register word address
//   i_wr_en         write strobe
//   i_rd_en         read strobe
//   i_wdata         write data (bits at and above p_num_gpios ignored)
//   o_rdata         registered read data, zero-extended
//   o_ack           one-cycle acknowledge after any access
//   i_gpio_in       raw pad inputs, asynchronous to i_clk
//   o_gpio_out      pad output values
//   o_gpio_out_en   pad output enables
//   o_gpio_pullup   pad pull-up enables
//   o_gpio_pulldown pad pull-down enables (pull-up wins when both set)
//   o_irq           level interrupt, OR of IRQ_STATUS & IRQ_EN
module gpio_bank #(
  parameter int p_num_gpios    = 24,
  parameter int p_sync_stages  = 2,
  parameter int p_debounce_pw2 = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [2:0]             i_addr,
  input  logic                   i_wr_en,
  input  logic                   i_rd_en,
  input  logic [31:0]            i_wdata,
  output logic [31:0]            o_rdata,
  output logic                   o_ack,
  input  logic [p_num_gpios-1:0] i_gpio_in,
  output logic [p_num_gpios-1:0] o_gpio_out,
  output logic [p_num_gpios-1:0] o_gpio_out_en,
  output logic [p_num_gpios-1:0] o_gpio_pullup,
  output logic [p_num_gpios-1:0] o_gpio_pulldown,
  output logic                   o_irq
);

  localparam int N = p_num_gpios;

  logic [N-1:0] out_q;
  logic [N-1:0] out_en_q;
  logic [N-1:0] pullup_q;
  logic [N-1:0] pulldown_q;
  logic [N-1:0] irq_en_q;
  logic [N-1:0] irq_mode_q;
  logic [N-1:0] irq_status_q;
  logic [N-1:0] sync_q [p_sync_stages];
  logic [N-1:0] filt;
  logic [N-1:0] filt_d1_q;
  logic [N-1:0] wdata_n;
  logic [N-1:0] w1c;
  logic [N-1:0] edge_evt;
  logic [31:0]  rd_word;
  logic [31:0]  rdata_q;
  logic         ack_q;
  logic         unused_bits;

  assign wdata_n = i_wdata[N-1:0];

  // Upper write-data bits are intentionally discarded; this keeps them
  // visibly consumed without affecting any logic.
  assign unused_bits = ^i_wdata;

  // Configuration registers. Pad controls come straight from these flops.
  // Writes to IN (4) and IRQ_STATUS (7) are not stored here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q      <= '0;
      out_en_q   <= '0;
      pullup_q   <= '0;
      pulldown_q <= '0;
      irq_en_q   <= '0;
      irq_mode_q <= '0;
    end else if (i_wr_en) begin
      case (i_addr)
        3'd0:    out_q      <= wdata_n;
        3'd1:    out_en_q   <= wdata_n;
        3'd2:    pullup_q   <= wdata_n;
        3'd3:    pulldown_q <= wdata_n;
        3'd5:    irq_en_q   <= wdata_n;
        3'd6:    irq_mode_q <= wdata_n;
        default: ;
      endcase
    end
  end

  // Multi-flop synchronizer chain on the raw pad inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < p_sync_stages; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_gpio_in;
      for (int s = 1; s < p_sync_stages; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_BANK_DEBOUNCE_EN
  logic [p_debounce_pw2-1:0] db_cnt_q [N];
  logic [N-1:0]              filt_q;

  // Debounce: a pin's filtered value only follows the synchronized value
  // once they have disagreed for a full 2^p_debounce_pw2 cycles in a row.
  // Any agreement restarts the count, so short glitches are swallowed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q <= '0;
      for (int i = 0; i < N; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync_q[p_sync_stages-1][i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == '1) begin
          filt_q[i]   <= sync_q[p_sync_stages-1][i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  localparam logic [31:0] c_db_pw2 = p_debounce_pw2;
  logic unused_cfg;

  assign unused_cfg = ^c_db_pw2;
  assign filt       = sync_q[p_sync_stages-1];
`endif

  // Edge detection compares the filtered value with its one-cycle-old copy.
  // Mode only selects which direction counts, so changing the mode with a
  // stable input never produces an event.
  always_comb begin
    w1c      = '0;
    edge_evt = ((filt & ~filt_d1_q) & ~irq_mode_q) |
               ((~filt & filt_d1_q) & irq_mode_q);
    if (i_wr_en && (i_addr == 3'd7)) w1c = wdata_n;
  end

  // Sticky status: set is ORed in after the clear so a coincident edge
  // survives a write-1-to-clear. Delayed copy resets to 0 so a pin held
  // high through reset is seen as a rising edge afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_d1_q    <= '0;
      irq_status_q <= '0;
    end else begin
      filt_d1_q    <= filt;
      irq_status_q <= (irq_status_q & ~w1c) | edge_evt;
    end
  end

  // Read mux built from current register contents, so a simultaneous
  // write returns the pre-write value.
  always_comb begin
    rd_word = '0;
    case (i_addr)
      3'd0: rd_word[N-1:0] = out_q;
      3'd1: rd_word[N-1:0] = out_en_q;
      3'd2: rd_word[N-1:0] = pullup_q;
      3'd3: rd_word[N-1:0] = pulldown_q;
      3'd4: rd_word[N-1:0] = filt;
      3'd5: rd_word[N-1:0] = irq_en_q;
      3'd6: rd_word[N-1:0] = irq_mode_q;
      3'd7: rd_word[N-1:0] = irq_status_q;
    endcase
  end

  // Bus response: ack one cycle after any access, read data held between reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= i_wr_en | i_rd_en;
      if (i_rd_en) rdata_q <= rd_word;
    end
  end

  assign o_rdata         = rdata_q;
  assign o_ack           = ack_q;
  assign o_gpio_out      = out_q;
  assign o_gpio_out_en   = out_en_q;
  assign o_gpio_pullup   = pullup_q;
  assign o_gpio_pulldown = pulldown_q & ~pullup_q;
  assign o_irq           = |(irq_status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank -- directed self-checking bench for gpio_bank (default
// parameters). Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point. When GPIO_BANK_DEBOUNCE_EN is defined the
// input latency grows by 16 cycles and the glitch-rejection test is added.
module tb_gpio_bank;

  localparam int N = 24;
`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int LAT = 2 + 16;
`else
  localparam int LAT = 2;
`endif

  logic          i_clk;
  logic          i_rst;
  logic [2:0]    i_addr;
  logic          i_wr_en;
  logic          i_rd_en;
  logic [31:0]   i_wdata;
  logic [31:0]   o_rdata;
  logic          o_ack;
  logic [N-1:0]  i_gpio_in;
  logic [N-1:0]  o_gpio_out;
  logic [N-1:0]  o_gpio_out_en;
  logic [N-1:0]  o_gpio_pullup;
  logic [N-1:0]  o_gpio_pulldown;
  logic          o_irq;

  int check_cnt = 0;
  int pass_cnt  = 0;

  gpio_bank #(
    .p_num_gpios   (N),
    .p_sync_stages (2),
    .p_debounce_pw2(4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_addr         (i_addr),
    .i_wr_en        (i_wr_en),
    .i_rd_en        (i_rd_en),
    .i_wdata        (i_wdata),
    .o_rdata        (o_rdata),
    .o_ack          (o_ack),
    .i_gpio_in      (i_gpio_in),
    .o_gpio_out     (o_gpio_out),
    .o_gpio_out_en  (o_gpio_out_en),
    .o_gpio_pullup  (o_gpio_pullup),
    .o_gpio_pulldown(o_gpio_pulldown),
    .o_irq          (o_irq)
  );

  // 10-unit clock period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    i_addr  = a;
    i_wdata = d;
    i_wr_en = 1'b1;
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    i_addr  = a;
    i_rd_en = 1'b1;
    @(posedge i_clk);
    #1;
    i_rd_en = 1'b0;
    d = o_rdata;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_addr = '0; i_wr_en = 1'b0; i_rd_en = 1'b0;
    i_wdata = '0; i_gpio_in = '0;
    #3;
    check_cnt++;
    if ({o_gpio_out, o_gpio_out_en, o_gpio_pullup, o_gpio_pulldown} !== '0)
      $display("[TB] FAIL reset_pads: got %h %h %h %h expected all 0",
               o_gpio_out, o_gpio_out_en, o_gpio_pullup, o_gpio_pulldown);
    else pass_cnt++;
    check_cnt++;
    if ({o_rdata, o_ack, o_irq} !== 34'd0)
      $display("[TB] FAIL reset_bus: rdata %h ack %b irq %b expected 0 0 0",
               o_rdata, o_ack, o_irq);
    else pass_cnt++;
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_out_regs();
    logic [31:0] d;
    bus_write(3'd0, 32'h0000_A5A5);
    check_cnt++;
    if (o_gpio_out !== 24'h00A5A5)
      $display("[TB] FAIL out_write: got %h expected %h", o_gpio_out, 24'h00A5A5);
    else pass_cnt++;
    check_cnt++;
    if (o_ack !== 1'b1)
      $display("[TB] FAIL ack_after_write: got %b expected 1", o_ack);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (o_ack !== 1'b0)
      $display("[TB] FAIL ack_one_cycle: got %b expected 0", o_ack);
    else pass_cnt++;
    bus_write(3'd1, 32'h00FF_FFFF);
    check_cnt++;
    if (o_gpio_out_en !== 24'hFFFFFF || o_ack !== 1'b1)
      $display("[TB] FAIL out_en_write: got %h ack %b expected ffffff ack 1",
               o_gpio_out_en, o_ack);
    else pass_cnt++;
    bus_write(3'd1, 32'hFF00_FF00);
    bus_read(3'd1, d);
    check_cnt++;
    if (d !== 32'h0000_FF00)
      $display("[TB] FAIL upper_bits_ignored: got %h expected %h", d, 32'h0000_FF00);
    else pass_cnt++;
    bus_write(3'd4, 32'h00FF_FFFF);
    bus_read(3'd4, d);
    check_cnt++;
    if (d !== 32'h0)
      $display("[TB] FAIL in_write_ignored: got %h expected 0", d);
    else pass_cnt++;
  endtask

  task automatic test_pulls();
    bus_write(3'd2, 32'h0000_0003);
    bus_write(3'd3, 32'h0000_0006);
    check_cnt++;
    if (o_gpio_pullup !== 24'h000003)
      $display("[TB] FAIL pullup: got %h expected %h", o_gpio_pullup, 24'h000003);
    else pass_cnt++;
    check_cnt++;
    if (o_gpio_pulldown !== 24'h000004)
      $display("[TB] FAIL pulldown_priority: got %h expected %h", o_gpio_pulldown, 24'h000004);
    else pass_cnt++;
  endtask

  task automatic test_input_irq();
    logic [31:0] d;
    bus_write(3'd5, 32'h0000_0020);
    bus_write(3'd6, 32'h0000_0000);
    i_gpio_in[5] = 1'b1;
    repeat (LAT - 1) tick();
    bus_read(3'd4, d);
    check_cnt++;
    if (d !== 32'h0 || o_irq !== 1'b0)
      $display("[TB] FAIL in_latency_early: got %h irq %b expected 0 irq 0", d, o_irq);
    else pass_cnt++;
    bus_read(3'd4, d);
    check_cnt++;
    if (d !== 32'h0000_0020)
      $display("[TB] FAIL in_latency: got %h expected %h", d, 32'h0000_0020);
    else pass_cnt++;
    check_cnt++;
    if (o_irq !== 1'b1)
      $display("[TB] FAIL irq_rise: got %b expected 1", o_irq);
    else pass_cnt++;
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0000_0020)
      $display("[TB] FAIL status_rise: got %h expected %h", d, 32'h0000_0020);
    else pass_cnt++;
    bus_write(3'd7, 32'h0000_0020);
    check_cnt++;
    if (o_irq !== 1'b0)
      $display("[TB] FAIL irq_w1c: got %b expected 0", o_irq);
    else pass_cnt++;
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0)
      $display("[TB] FAIL status_w1c: got %h expected 0", d);
    else pass_cnt++;
  endtask

  task automatic test_falling_w1c();
    logic [31:0] d;
    bus_write(3'd6, 32'h0000_0008);
    i_gpio_in[3] = 1'b1;
    repeat (LAT + 3) tick();
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0)
      $display("[TB] FAIL falling_ignores_rise: got %h expected 0", d);
    else pass_cnt++;
    i_gpio_in[3] = 1'b0;
    repeat (LAT) tick();
    bus_write(3'd7, 32'h0000_0008);
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0000_0008)
      $display("[TB] FAIL set_beats_w1c: got %h expected %h", d, 32'h0000_0008);
    else pass_cnt++;
    check_cnt++;
    if (o_irq !== 1'b0)
      $display("[TB] FAIL irq_masked: got %b expected 0", o_irq);
    else pass_cnt++;
    bus_write(3'd7, 32'h0000_0008);
    bus_write(3'd6, 32'h0000_0000);
    tick();
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0)
      $display("[TB] FAIL mode_write_no_event: got %h expected 0", d);
    else pass_cnt++;
  endtask

  task automatic test_rw_collision();
    i_addr  = 3'd0;
    i_wdata = 32'h0012_3456;
    i_wr_en = 1'b1;
    i_rd_en = 1'b1;
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    check_cnt++;
    if (o_rdata !== 32'h0000_A5A5 || o_ack !== 1'b1)
      $display("[TB] FAIL rw_old_value: got %h ack %b expected %h ack 1",
               o_rdata, o_ack, 32'h0000_A5A5);
    else pass_cnt++;
    check_cnt++;
    if (o_gpio_out !== 24'h123456)
      $display("[TB] FAIL rw_write_done: got %h expected %h", o_gpio_out, 24'h123456);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (o_rdata !== 32'h0000_A5A5 || o_ack !== 1'b0)
      $display("[TB] FAIL rdata_hold: got %h ack %b expected %h ack 0",
               o_rdata, o_ack, 32'h0000_A5A5);
    else pass_cnt++;
  endtask

`ifdef GPIO_BANK_DEBOUNCE_EN
  task automatic test_debounce_glitch();
    logic [31:0] d;
    i_gpio_in[0] = 1'b1;
    repeat (10) tick();
    i_gpio_in[0] = 1'b0;
    repeat (30) tick();
    bus_read(3'd4, d);
    check_cnt++;
    if (d[0] !== 1'b0)
      $display("[TB] FAIL glitch_in: got %b expected 0", d[0]);
    else pass_cnt++;
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0)
      $display("[TB] FAIL glitch_status: got %h expected 0", d);
    else pass_cnt++;
    i_gpio_in[0] = 1'b1;
    repeat (LAT - 1) tick();
    bus_read(3'd4, d);
    check_cnt++;
    if (d[0] !== 1'b0)
      $display("[TB] FAIL debounce_early: got %b expected 0", d[0]);
    else pass_cnt++;
    bus_read(3'd4, d);
    check_cnt++;
    if (d[0] !== 1'b1)
      $display("[TB] FAIL debounce_level: got %b expected 1", d[0]);
    else pass_cnt++;
    i_gpio_in[0] = 1'b0;
    repeat (LAT + 3) tick();
    bus_write(3'd7, 32'h00FF_FFFF);
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] d;
    bus_write(3'd0, 32'h00FF_FFFF);
    check_cnt++;
    if (o_gpio_out !== 24'hFFFFFF)
      $display("[TB] FAIL out_all_ones: got %h expected ffffff", o_gpio_out);
    else pass_cnt++;
    i_addr  = 3'd0;
    i_rd_en = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_cnt++;
    if ({o_gpio_out, o_gpio_out_en, o_gpio_pullup, o_gpio_pulldown} !== '0)
      $display("[TB] FAIL async_pads: got %h %h %h %h expected all 0",
               o_gpio_out, o_gpio_out_en, o_gpio_pullup, o_gpio_pulldown);
    else pass_cnt++;
    check_cnt++;
    if ({o_rdata, o_ack, o_irq} !== 34'd0)
      $display("[TB] FAIL async_bus: rdata %h ack %b irq %b expected 0 0 0",
               o_rdata, o_ack, o_irq);
    else pass_cnt++;
    i_rd_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    check_cnt++;
    if (o_ack !== 1'b0)
      $display("[TB] FAIL no_ack_after_abort: got %b expected 0", o_ack);
    else pass_cnt++;
    repeat (LAT) tick();
    bus_read(3'd7, d);
    check_cnt++;
    if (d !== 32'h0000_0020)
      $display("[TB] FAIL held_high_through_reset: got %h expected %h", d, 32'h0000_0020);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_out_regs();
    test_pulls();
    test_input_irq();
    test_falling_w1c();
    test_rw_collision();
`ifdef GPIO_BANK_DEBOUNCE_EN
    test_debounce_glitch();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
